// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch resolution bus: decode-time prediction read, EX resolution inputs,
// redirect/flush outputs and statistics.
interface branch_resolve_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic [ADDR_W-1:0] i_id_pc;
    logic              o_id_pred_taken;
    logic              i_ex_valid;
    logic [ADDR_W-1:0] i_ex_pc;
    logic              i_ex_pred_taken;
    logic              i_zero;
    logic              i_jump;
    logic              i_beq;
    logic              i_bne;
    logic [1:0]        o_pc_src;
    logic              o_kill1;
    logic              o_kill2;
    logic              o_mispredict;
    logic [CNT_W-1:0]  o_br_cnt;
    logic [CNT_W-1:0]  o_mis_cnt;

    modport master (
        output i_id_pc, i_ex_valid, i_ex_pc, i_ex_pred_taken, i_zero, i_jump, i_beq, i_bne,
        input  o_id_pred_taken, o_pc_src, o_kill1, o_kill2, o_mispredict, o_br_cnt, o_mis_cnt
    );

    modport slave (
        input  i_id_pc, i_ex_valid, i_ex_pc, i_ex_pred_taken, i_zero, i_jump, i_beq, i_bne,
        output o_id_pred_taken, o_pc_src, o_kill1, o_kill2, o_mispredict, o_br_cnt, o_mis_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution with a 2-bit saturating-counter BHT, PC-source select,
// pipeline kill generation and saturating branch/mispredict statistics.
module branch_resolve_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned PREDICT   = 1,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    branch_resolve_unit_if.slave br
);

    localparam logic [1:0] CntStrongNt = 2'b00;
    localparam logic [1:0] CntWeakNt   = 2'b01;
    localparam logic [1:0] CntStrongT  = 2'b11;

    localparam logic [1:0] SrcSeq     = 2'b00;
    localparam logic [1:0] SrcJump    = 2'b01;
    localparam logic [1:0] SrcBranch  = 2'b10;
    localparam logic [1:0] SrcRecover = 2'b11;

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_upd;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] id_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             cond;
    logic             taken;
    logic             pred;
    logic             mis;
    logic             jump_go;

    // Only the index bits of the PCs address the table; the rest are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{br.i_id_pc, br.i_ex_pc};

    assign id_idx = br.i_id_pc[IDX_W+1:2];
    assign ex_idx = br.i_ex_pc[IDX_W+1:2];

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up) begin
            return (cnt == CntStrongT) ? cnt : cnt + 2'b01;
        end
        return (cnt == CntStrongNt) ? cnt : cnt - 2'b01;
    endfunction

    // Reset masks resolution so a branch in the reset cycle neither redirects nor trains.
    always_comb begin
        cond    = br.i_ex_valid & (br.i_beq | br.i_bne) & ~i_rst;
        taken   = (br.i_beq & br.i_zero) | (br.i_bne & ~br.i_zero);
        pred    = (PREDICT != 0) ? br.i_ex_pred_taken : 1'b0;
        mis     = cond & (taken != pred);
        jump_go = br.i_ex_valid & br.i_jump & ~(br.i_beq | br.i_bne) & ~i_rst;
        bht_upd = sat_step(bht_q[ex_idx], taken);
    end

    always_comb begin
        br.o_pc_src     = SrcSeq;
        br.o_kill1      = 1'b0;
        br.o_kill2      = 1'b0;
        br.o_mispredict = mis;
        if (mis && taken) begin
            br.o_pc_src = SrcBranch;
            br.o_kill1  = 1'b1;
            br.o_kill2  = 1'b1;
        end else if (mis) begin
            br.o_pc_src = SrcRecover;
            br.o_kill1  = 1'b1;
            br.o_kill2  = 1'b1;
        end else if (jump_go) begin
            br.o_pc_src = SrcJump;
            br.o_kill1  = 1'b1;
        end
    end

    // Plain array read: a same-cycle update to this index is only seen after the edge.
    always_comb begin
        br.o_id_pred_taken = 1'b0;
        if ((PREDICT != 0) && !i_rst) begin
            br.o_id_pred_taken = bht_q[id_idx][1];
        end
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (cond && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (mis && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    // Table trains even in static mode so a switch to dynamic prediction starts warm.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bht_q     <= '{default: CntWeakNt};
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (cond) begin
                bht_q[ex_idx] <= bht_upd;
            end
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br.o_br_cnt  = br_cnt_q;
    assign br.o_mis_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: three instances (default, 4-entry/3-bit counters, static predict) share
// one stimulus stream; each checks the behaviour its parameters expose.
module tb_branch_resolve_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] id_pc;
    logic [31:0] ex_pc;
    logic        ex_valid, ex_pred, zero, jump, beq, bne;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    branch_resolve_unit_if #(.ADDR_W(32), .CNT_W(16)) bus0 ();
    branch_resolve_unit_if #(.ADDR_W(32), .CNT_W(3))  bus1 ();
    branch_resolve_unit_if #(.ADDR_W(32), .CNT_W(16)) bus2 ();

    assign bus0.i_id_pc = id_pc;    assign bus1.i_id_pc = id_pc;    assign bus2.i_id_pc = id_pc;
    assign bus0.i_ex_valid = ex_valid;
    assign bus1.i_ex_valid = ex_valid;
    assign bus2.i_ex_valid = ex_valid;
    assign bus0.i_ex_pc = ex_pc;    assign bus1.i_ex_pc = ex_pc;    assign bus2.i_ex_pc = ex_pc;
    assign bus0.i_ex_pred_taken = ex_pred;
    assign bus1.i_ex_pred_taken = ex_pred;
    assign bus2.i_ex_pred_taken = ex_pred;
    assign bus0.i_zero = zero;      assign bus1.i_zero = zero;      assign bus2.i_zero = zero;
    assign bus0.i_jump = jump;      assign bus1.i_jump = jump;      assign bus2.i_jump = jump;
    assign bus0.i_beq = beq;        assign bus1.i_beq = beq;        assign bus2.i_beq = beq;
    assign bus0.i_bne = bne;        assign bus1.i_bne = bne;        assign bus2.i_bne = bne;

    branch_resolve_unit #(.ADDR_W(32), .BHT_DEPTH(16), .PREDICT(1), .CNT_W(16)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .br    (bus0.slave)
    );

    branch_resolve_unit #(.ADDR_W(32), .BHT_DEPTH(4), .PREDICT(1), .CNT_W(3)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .br    (bus1.slave)
    );

    branch_resolve_unit #(.ADDR_W(32), .BHT_DEPTH(16), .PREDICT(0), .CNT_W(16)) u_dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .br    (bus2.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [1:0] src, input logic k1,
                        input logic k2, input logic m);
        check_eq({tag, ".src"}, {30'd0, bus0.o_pc_src}, {30'd0, src});
        check_eq({tag, ".k1"}, {31'd0, bus0.o_kill1}, {31'd0, k1});
        check_eq({tag, ".k2"}, {31'd0, bus0.o_kill2}, {31'd0, k2});
        check_eq({tag, ".mis"}, {31'd0, bus0.o_mispredict}, {31'd0, m});
    endtask

    task automatic chk_cnt0(input string tag, input int unsigned br_n, input int unsigned mis_n);
        check_eq({tag, ".br"}, {16'd0, bus0.o_br_cnt}, br_n);
        check_eq({tag, ".miscnt"}, {16'd0, bus0.o_mis_cnt}, mis_n);
    endtask

    task automatic ex_set(input logic v, input logic [31:0] pc, input logic p, input logic z,
                          input logic j, input logic q, input logic n);
        ex_valid = v; ex_pc = pc; ex_pred = p; zero = z; jump = j; beq = q; bne = n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        id_pc = 32'h40;
        ex_set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Mispredicting beq held during reset: outputs masked, no training or counting
        ex_set(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk0("rst_res", 2'b00, 1'b0, 1'b0, 1'b0);
        check_eq("rst_pred", {31'd0, bus0.o_id_pred_taken}, 32'd0);
        tick();
        rst = 1'b0;
        ex_set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_cnt0("post_rst", 0, 0);
        check_eq("post_rst_pred", {31'd0, bus0.o_id_pred_taken}, 32'd0);

        // Three mispredicted taken beq at 0x40: 01 -> 10 -> 11 -> 11
        for (int i = 0; i < 3; i++) begin
            ex_set(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            #1;
            chk0("beq_t", 2'b10, 1'b1, 1'b1, 1'b1);
            if (i == 0) check_eq("rdw_old", {31'd0, bus0.o_id_pred_taken}, 32'd0);
            tick();
            check_eq("beq_pred", {31'd0, bus0.o_id_pred_taken}, 32'd1);
            chk_cnt0("beq_t_cnt", i + 1, i + 1);
        end

        // Correctly predicted taken: no redirect; static instance sees a mispredict
        ex_set(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk0("beq_ok", 2'b00, 1'b0, 1'b0, 1'b0);
        check_eq("static_src", {30'd0, bus2.o_pc_src}, 32'd2);
        check_eq("static_mis", {31'd0, bus2.o_mispredict}, 32'd1);
        tick();
        check_eq("sat_pred", {31'd0, bus0.o_id_pred_taken}, 32'd1);
        check_eq("static_pred", {31'd0, bus2.o_id_pred_taken}, 32'd0);
        chk_cnt0("beq_ok_cnt", 4, 3);

        // bne not taken, predicted taken: recovery; 11 -> 10 -> 01
        for (int i = 0; i < 2; i++) begin
            ex_set(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            #1;
            chk0("bne_nt", 2'b11, 1'b1, 1'b1, 1'b1);
            check_eq("static_nt_src", {30'd0, bus2.o_pc_src}, 32'd0);
            tick();
            check_eq("bne_pred", {31'd0, bus0.o_id_pred_taken}, (i == 0) ? 32'd1 : 32'd0);
            chk_cnt0("bne_nt_cnt", 5 + i, 4 + i);
        end

        // bne taken, predicted not-taken
        ex_set(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk0("bne_t", 2'b10, 1'b1, 1'b1, 1'b1);
        tick();
        chk_cnt0("bne_t_cnt", 7, 6);

        // Jump: redirect, IF/ID kill only, counters unchanged
        ex_set(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk0("jmp", 2'b01, 1'b1, 1'b0, 1'b0);
        tick();
        chk_cnt0("jmp_cnt", 7, 6);

        // Jump with beq: branch path wins
        ex_set(1'b1, 32'h48, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk0("jmp_beq", 2'b10, 1'b1, 1'b1, 1'b1);
        tick();
        chk_cnt0("jmp_beq_cnt", 8, 7);

        // Invalid EX slot: nothing happens
        ex_set(1'b0, 32'h48, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk0("inval", 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        chk_cnt0("inval_cnt", 8, 7);

        // Mid-stream reset with a branch on the bus
        ex_set(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk0("rst_mid", 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        ex_set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_cnt0("rst_mid_cnt", 0, 0);

        // Aliasing in the 4-entry table: 0x00 and 0x10 share index 0
        id_pc = 32'h10;
        ex_set(1'b1, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check_eq("alias_rdw", {31'd0, bus1.o_id_pred_taken}, 32'd0);
        check_eq("alias_src", {30'd0, bus1.o_pc_src}, 32'd2);
        tick();
        check_eq("alias_pred", {31'd0, bus1.o_id_pred_taken}, 32'd1);
        check_eq("noalias_pred", {31'd0, bus0.o_id_pred_taken}, 32'd0);

        // Eight more mispredicts: 9 total saturates 3-bit counters at 7
        for (int i = 0; i < 8; i++) begin
            ex_set(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        ex_set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("sat_br", {29'd0, bus1.o_br_cnt}, 32'd7);
        check_eq("sat_mis", {29'd0, bus1.o_mis_cnt}, 32'd7);
        chk_cnt0("wide_cnt", 9, 9);

        // Reset returns the trained entry to weak not-taken and clears counters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        id_pc = 32'h00;
        #1;
        check_eq("rst2_br", {29'd0, bus1.o_br_cnt}, 32'd0);
        check_eq("rst2_mis", {29'd0, bus1.o_mis_cnt}, 32'd0);
        check_eq("rst2_pred", {31'd0, bus1.o_id_pred_taken}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Next-generation EX-stage branch/jump resolution block for the MIPS pipeline.
- Adds a parametrised branch history table (BHT) of 2-bit saturating counters, read at decode to predict conditional branches and updated at EX resolution.
- Generates PC-source select and IF/ID and ID/EX kill signals for jump redirects and branch mispredict recovery.
- Keeps branch/mispredict statistics counters.

Parameters:
- ADDR_W, 32, PC width in bits.
- BHT_DEPTH, 16, number of BHT entries; power of two, minimum 2.
- IDX_W, log2(BHT_DEPTH), BHT index width; derived, not overridden.
- PREDICT, 1, 0 = static not-taken (BHT ignored, prediction always 0); 1 = dynamic BHT.
- CNT_W, 16, width of the statistics counters.

Ports:
- i_clk, input, 1, clock; all state updates on the rising edge.
- i_rst, input, 1, reset, synchronous, active-high.
- i_id_pc, input, ADDR_W, PC of the instruction in decode.
- o_id_pred_taken, output, 1, prediction for the decode instruction.
- i_ex_valid, input, 1, EX holds a real (non-bubble, non-stalled) instruction.
- i_ex_pc, input, ADDR_W, PC of the EX instruction.
- i_ex_pred_taken, input, 1, prediction carried down the pipeline with the EX instruction.
- i_zero, input, 1, ALU zero flag.
- i_jump, input, 1, EX instruction is j/jal.
- i_beq, input, 1, EX instruction is beq.
- i_bne, input, 1, EX instruction is bne.
- o_pc_src, output, 2, next-PC select: 00 sequential/predicted, 01 jump target, 10 branch target, 11 recovery to i_ex_pc+4.
- o_kill1, output, 1, flush IF/ID.
- o_kill2, output, 1, flush ID/EX.
- o_mispredict, output, 1, EX branch mispredicted this cycle.
- o_br_cnt, output, CNT_W, count of resolved conditional branches.
- o_mis_cnt, output, CNT_W, count of mispredicts.

Behaviour:
- BHT index = pc[IDX_W+1:2] (word-aligned PCs).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Prediction = counter MSB.
- o_id_pred_taken: combinational read of entry index(i_id_pc). Forced to 0 when PREDICT=0 or i_rst=1.
- Read-during-write to the same index returns the pre-update (old) value; no bypass.
- cond = i_ex_valid & (i_beq | i_bne).
- taken = (i_beq & i_zero) | (i_bne & ~i_zero).
- pred = i_ex_pred_taken when PREDICT=1; 0 when PREDICT=0.
- mis = cond & (taken != pred).
- Combinational outputs, same cycle as EX inputs, priority top-down:
  - mis & taken: pc_src=10, kill1=1, kill2=1.
  - mis & ~taken: pc_src=11, kill1=1, kill2=1.
  - i_ex_valid & i_jump & ~cond: pc_src=01, kill1=1, kill2=0.
  - otherwise (incl. correct predictions, i_ex_valid=0): pc_src=00, kills 0.
- o_mispredict = mis.
- If i_jump and i_beq/i_bne are both set, the branch path has priority and the jump is ignored.
- When i_ex_valid=0, all EX-derived outputs are 0 and no state changes.
- BHT update, on the rising edge when cond=1 and i_rst=0:
  - entry index(i_ex_pc) saturating +1 if taken, -1 if not.
  - 11 stays 11 on taken; 00 stays 00 on not-taken.
  - Updated even when PREDICT=0, so the table stays warm for a mode switch in simulation.
- Statistics, on the rising edge:
  - o_br_cnt += 1 when cond.
  - o_mis_cnt += 1 when mis.
  - Both saturate at 2^CNT_W-1; no wrap.
- Reset (i_rst=1 at a rising edge):
  - all BHT entries <= 01.
  - o_br_cnt, o_mis_cnt <= 0.
  - Reset applies in one cycle, including mid-operation; a branch resolving in a reset cycle causes no update and no count.
- Combinational outputs during reset: o_pc_src=00, o_kill1=0, o_kill2=0, o_mispredict=0.
- Latency: resolution outputs 0 cycles (combinational). BHT/counter effects are visible from the cycle after the edge.

Test Plan:
- Reset, then read any i_id_pc -> o_id_pred_taken=0, counters 0; with PREDICT=1, entries read as 01 (weak not-taken).
- beq at pc=0x40, i_zero=1, pred=0, valid -> pc_src=10, kill1=kill2=1, mispredict=1. Repeat the same resolution twice -> entry 0x40 goes 01->10->11; i_id_pc=0x40 then predicts 1. A fourth taken keeps it at 11.
- bne at pc=0x40, i_zero=1 (not taken), pred=1 -> pc_src=11, kills 1/1. Entry decrements one step. o_mis_cnt increments by 1, o_br_cnt by 1.
- Jump with i_ex_valid=1, no branch -> pc_src=01, kill1=1, kill2=0, counters unchanged. Same inputs with i_ex_valid=0 -> all outputs 0.
- Aliasing: BHT_DEPTH=4, pc=0x00 and pc=0x10 share an index -> training 0x00 taken changes the prediction for 0x10. Same-cycle read/write of one index returns the old value.
- CNT_W=3: 9 mispredicting branches -> o_br_cnt=o_mis_cnt=7 (saturated). Assert i_rst mid-stream -> next cycle counters 0 and all entries 01. PREDICT=0 -> o_id_pred_taken stays 0 and every taken branch gives pc_src=10.
